// File: rtl/alu_operand_collector.sv
// -----------------------------------------------------------------------------
// alu_operand_collector
//
// Upstream stage of the ALU. Operand beats arrive from the stimulus source with
// OPA and OPB possibly in different cycles. A half-transaction is held here,
// together with the CMD/MODE/CIN of its first beat, until the partner operand
// arrives. Then one registered transaction is issued to the ALU with
// INP_VALID=2'b11. Single-operand commands (s_single) are issued without
// pairing. A pending operand whose partner does not arrive within TIMEOUT
// cycles is dropped, and timeout_err pulses, so the ALU never receives a
// stale half-transaction.
//
// Parameters
//   DATA_WIDTH  operand width
//   CMD_WIDTH   command width
//   TIMEOUT     cycles a pending operand waits for its partner
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high; has priority over CE
//   CE           clock enable; when low, all state and outputs hold
//   s_opa/s_opb  upstream operands
//   s_cin        upstream carry-in
//   s_mode       upstream mode (1 = arithmetic, 0 = logical)
//   s_cmd        upstream command
//   s_inp_valid  bit0 = s_opa valid, bit1 = s_opb valid, 00 = no beat
//   s_single     beat is a complete single-operand command
//   OPA/OPB      operands to the ALU (registered, hold the last issued value)
//   CIN/MODE/CMD control to the ALU (registered, hold the last issued value)
//   INP_VALID    nonzero for exactly one cycle per issue
//   busy         high while a half-transaction is pending
//   timeout_err  one-cycle pulse when a pending operand is abandoned
// -----------------------------------------------------------------------------
module alu_operand_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CE,
    input  logic [DATA_WIDTH-1:0] s_opa,
    input  logic [DATA_WIDTH-1:0] s_opb,
    input  logic                  s_cin,
    input  logic                  s_mode,
    input  logic [CMD_WIDTH-1:0]  s_cmd,
    input  logic [1:0]            s_inp_valid,
    input  logic                  s_single,
    output logic [DATA_WIDTH-1:0] OPA,
    output logic [DATA_WIDTH-1:0] OPB,
    output logic                  CIN,
    output logic                  MODE,
    output logic [CMD_WIDTH-1:0]  CMD,
    output logic [1:0]            INP_VALID,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_B = 2'b01,   // holding operand A, waiting for B
        WAIT_A = 2'b10    // holding operand B, waiting for A
    } state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;

    // One pending-operand register serves both wait states: it holds A in
    // WAIT_B and B in WAIT_A.
    logic [DATA_WIDTH-1:0] pend_data, pend_data_nx;
    logic [CMD_WIDTH-1:0]  pend_cmd, pend_cmd_nx;
    logic                  pend_mode, pend_mode_nx;
    logic                  pend_cin, pend_cin_nx;

    logic [DATA_WIDTH-1:0] opa_nx, opb_nx;
    logic                  cin_nx, mode_nx;
    logic [CMD_WIDTH-1:0]  cmd_nx;
    logic [1:0]            iv_nx;
    logic                  terr_nx;

    logic                  beat;
    logic                  single_beat;

    assign beat        = |s_inp_valid;
    assign single_beat = s_single & beat;
    assign busy        = (state != IDLE);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        pend_data_nx = pend_data;
        pend_cmd_nx  = pend_cmd;
        pend_mode_nx = pend_mode;
        pend_cin_nx  = pend_cin;
        opa_nx       = OPA;
        opb_nx       = OPB;
        cin_nx       = CIN;
        mode_nx      = MODE;
        cmd_nx       = CMD;
        iv_nx        = 2'b00;
        terr_nx      = 1'b0;

        unique case (state)
            IDLE: begin
                if (beat) begin
                    if (s_single || (s_inp_valid == 2'b11)) begin
                        // Complete beat: issue straight from the inputs.
                        opa_nx  = s_opa;
                        opb_nx  = s_opb;
                        cin_nx  = s_cin;
                        mode_nx = s_mode;
                        cmd_nx  = s_cmd;
                        iv_nx   = s_inp_valid;
                    end else begin
                        // Half beat: latch it with its control and wait.
                        pend_data_nx = s_inp_valid[0] ? s_opa : s_opb;
                        pend_cmd_nx  = s_cmd;
                        pend_mode_nx = s_mode;
                        pend_cin_nx  = s_cin;
                        cnt_nx       = '0;
                        state_nx     = s_inp_valid[0] ? WAIT_B : WAIT_A;
                    end
                end
            end

            WAIT_B: begin
                if (single_beat) begin
                    opa_nx   = s_opa;
                    opb_nx   = s_opb;
                    cin_nx   = s_cin;
                    mode_nx  = s_mode;
                    cmd_nx   = s_cmd;
                    iv_nx    = s_inp_valid;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (s_inp_valid[1]) begin
                    // Partner arrived; control comes from the first beat.
                    opa_nx   = pend_data;
                    opb_nx   = s_opb;
                    cin_nx   = pend_cin;
                    mode_nx  = pend_mode;
                    cmd_nx   = pend_cmd;
                    iv_nx    = 2'b11;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (s_inp_valid[0]) begin
                    // A newer A replaces the pending one and restarts the wait.
                    pend_data_nx = s_opa;
                    pend_cmd_nx  = s_cmd;
                    pend_mode_nx = s_mode;
                    pend_cin_nx  = s_cin;
                    cnt_nx       = '0;
                end else if (cnt == CNT_LAST) begin
                    terr_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            WAIT_A: begin
                if (single_beat) begin
                    opa_nx   = s_opa;
                    opb_nx   = s_opb;
                    cin_nx   = s_cin;
                    mode_nx  = s_mode;
                    cmd_nx   = s_cmd;
                    iv_nx    = s_inp_valid;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (s_inp_valid[0]) begin
                    opa_nx   = s_opa;
                    opb_nx   = pend_data;
                    cin_nx   = pend_cin;
                    mode_nx  = pend_mode;
                    cmd_nx   = pend_cmd;
                    iv_nx    = 2'b11;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (s_inp_valid[1]) begin
                    pend_data_nx = s_opb;
                    pend_cmd_nx  = s_cmd;
                    pend_mode_nx = s_mode;
                    pend_cin_nx  = s_cin;
                    cnt_nx       = '0;
                end else if (cnt == CNT_LAST) begin
                    terr_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. With CE low everything holds, including
    // INP_VALID and timeout_err.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_data   <= '0;
            pend_cmd    <= '0;
            pend_mode   <= 1'b0;
            pend_cin    <= 1'b0;
            OPA         <= '0;
            OPB         <= '0;
            CIN         <= 1'b0;
            MODE        <= 1'b0;
            CMD         <= '0;
            INP_VALID   <= 2'b00;
            timeout_err <= 1'b0;
        end else if (CE) begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pend_data   <= pend_data_nx;
            pend_cmd    <= pend_cmd_nx;
            pend_mode   <= pend_mode_nx;
            pend_cin    <= pend_cin_nx;
            OPA         <= opa_nx;
            OPB         <= opb_nx;
            CIN         <= cin_nx;
            MODE        <= mode_nx;
            CMD         <= cmd_nx;
            INP_VALID   <= iv_nx;
            timeout_err <= terr_nx;
        end
    end

endmodule

// File: doc/alu_operand_collector.md
# alu_operand_collector

Upstream stage of the ALU. Accepts operand beats from the stimulus source, where OPA and OPB may arrive in different cycles, and pairs them with the CMD/MODE/CIN of the first beat. It then issues a single registered transaction to the ALU with INP_VALID=2'b11, or 01/10 for single-operand commands. A missing partner is abandoned after TIMEOUT cycles and flagged, so the ALU never sees a stale half-transaction.

## Interface
- DATA_WIDTH, 8, operand width (matches `DATA_WIDTH).
- CMD_WIDTH, 4, command width (matches `CMD_WIDTH).
- TIMEOUT, 16, cycles a pending operand waits for its partner.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; has priority over CE.
- CE  in  1  clock enable; when low, all state and outputs hold and inputs are ignored.
- s_opa  in  DATA_WIDTH  upstream operand A.
- s_opb  in  DATA_WIDTH  upstream operand B.
- s_cin  in  1  upstream carry-in.
- s_mode  in  1  upstream mode (1 = arithmetic, 0 = logical).
- s_cmd  in  CMD_WIDTH  upstream command.
- s_inp_valid  in  2  bit0 = s_opa valid, bit1 = s_opb valid; 00 = no beat.
- s_single  in  1  beat is a complete single-operand command; issue without pairing.
- OPA, OPB  out  DATA_WIDTH  to ALU, registered.
- CIN, MODE  out  1  to ALU, registered.
- CMD  out  CMD_WIDTH  to ALU, registered.
- INP_VALID  out  2  to ALU; nonzero for exactly one cycle per issue.
- busy  out  1  high while a half-transaction is pending.
- timeout_err  out  1  one-cycle pulse when a pending operand is abandoned.

## Operation
- States: IDLE, WAIT_B (holding A), WAIT_A (holding B). Timeout counter cnt is $clog2(TIMEOUT) bits wide.
- IDLE, beat 11: capture both operands plus CMD/MODE/CIN, then issue with INP_VALID=11.
- IDLE, beat 01 or 10 with s_single=1: issue immediately with INP_VALID equal to the beat.
- IDLE, beat 01 with s_single=0: capture A/CMD/MODE/CIN, go to WAIT_B, cnt=0. Beat 10 is symmetric and goes to WAIT_A.
- WAIT_B priority order, highest first:
  1. s_single beat: issue it, drop the pending operand, go to IDLE, no error.
  2. Beat with bit1 set (10 or 11): capture OPB only, keep the latched A/CMD/MODE/CIN, issue 11, go to IDLE. The new OPA and CMD in an 11 beat are ignored.
  3. Beat 01: overwrite A/CMD/MODE/CIN and restart cnt=0.
  4. No beat and cnt==TIMEOUT-1: pulse timeout_err, drop the pending operand, go to IDLE, no issue.
  5. Otherwise cnt++.
- WAIT_A mirrors WAIT_B with A and B swapped.
- Issue: OPA/OPB/CIN/MODE/CMD are loaded and INP_VALID set for one cycle, then INP_VALID returns to 00. Data outputs hold their last issued value.
- No backpressure: the ALU accepts every CE cycle.
- busy = (state != IDLE).

## Timing
- Reset (sync, sampled at edge): state=IDLE, cnt=0, OPA=OPB=0, CIN=MODE=0, CMD=0, INP_VALID=00, busy=0, timeout_err=0.
- Reset mid-WAIT discards the pending operand with no error pulse.
- Latency: a completing beat at edge t gives INP_VALID nonzero in cycle t→t+1. Back-to-back beats of 11 or single beats give one issue per cycle.
- Timeout: a first beat at edge t0 leaves its partner accepted at edges t0+1 through t0+TIMEOUT. With no beat, timeout_err is high in cycle t0+TIMEOUT→t0+TIMEOUT+1 and busy falls at the same edge.
- At the final edge, a completing beat wins over timeout.
- CE low: cnt does not advance and INP_VALID/timeout_err hold their current value. Stalled cycles do not count toward TIMEOUT.
- Counter wrap is impossible: cnt is cleared on every exit from WAIT.

## Test plan
- Paired beat: reset, then s_inp_valid=11, s_opa=8'h3C, s_opb=8'h05, s_cmd=0, s_mode=1 → next cycle INP_VALID=11, OPA=3C, OPB=05, CMD=0, MODE=1; following cycle INP_VALID=00.
- Split beat: 01 (A=8'h10, cmd=1), three idle cycles, then 10 (B=8'h20, cmd=7) → single issue with INP_VALID=11, OPA=10, OPB=20, CMD=1; busy high for four cycles.
- Timeout: beat 10 then 16 idle cycles → timeout_err pulses one cycle after the 16th edge; no INP_VALID issue; busy=0. The same test with the partner on the 16th cycle must issue with no error.
- Restart: beat 01 (A=1), 10 idle cycles, beat 01 (A=2), then 10 idle cycles → no timeout; a partner beat then issues OPA=2.
- CE stall: beat 01, CE low for 20 cycles, CE high, partner arrives on the next cycle → issue 11 with no timeout_err; outputs frozen during the stall.
- Reset mid-wait: beat 01, two cycles, reset for one cycle → all outputs zero, busy=0, no issue; a subsequent 10 beat is held pending rather than completing.
